// File: rtl/gelu_out_pack_axis.sv
// Packs the GELU stage's element stream into 32-bit AXI-Stream words,
// closing each frame with TLAST/TKEEP and flagging frame-length mismatches.
module gelu_out_pack_axis #(
    parameter int D_W = 8,
    parameter int MATRIXSIZE_W = 16,
    localparam int LANES = 32 / D_W,
    localparam int KW = LANES * D_W / 8,
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [MATRIXSIZE_W-1:0] frame_len,
    input  logic signed [D_W-1:0]   s_TDATA,
    input  logic                    s_TVALID,
    output logic                    s_TREADY,
    input  logic                    s_TLAST,
    output logic [31:0]             m_TDATA,
    output logic [KW-1:0]           m_TKEEP,
    output logic                    m_TVALID,
    input  logic                    m_TREADY,
    output logic                    m_TLAST,
    output logic                    frame_done,
    output logic                    len_err
);

    logic [LW-1:0]           lane_q;
    logic [31:0]             acc_q;
    logic [31:0]             m_data_q;
    logic [KW-1:0]           m_keep_q;
    logic                    m_valid_q;
    logic                    m_last_q;
    logic                    len_err_q;
    logic [MATRIXSIZE_W-1:0] elem_cnt_q;
    logic [MATRIXSIZE_W-1:0] frame_len_q;

    logic                    accept;
    logic                    first;
    logic                    len_hit;
    logic                    frame_end;
    logic                    err_hit;
    logic                    lane_full;
    logic                    word_done;
    logic [MATRIXSIZE_W-1:0] flen;
    logic [31:0]             shamt;
    logic [31:0]             word;
    logic [31:0]             nbytes;
    logic [KW-1:0]           keep;

    assign s_TREADY = ~m_valid_q | m_TREADY;
    assign accept   = s_TVALID & s_TREADY;
    assign first    = elem_cnt_q == '0;

    // The first element of a frame sees the live length, later ones the sample.
    assign flen      = first ? frame_len : frame_len_q;
    assign len_hit   = (flen != '0) && (elem_cnt_q == flen - 1'b1);
    assign frame_end = s_TLAST | len_hit;
    assign err_hit   = (flen != '0) & (s_TLAST ^ len_hit);
    assign lane_full = 32'(lane_q) == 32'(LANES - 1);
    assign word_done = lane_full | frame_end;

    always_comb begin
        shamt  = 32'(lane_q) * 32'(D_W);
        word   = acc_q | (32'($unsigned(s_TDATA)) << shamt);
        nbytes = ((32'(lane_q) + 32'd1) * 32'(D_W) + 32'd7) >> 3;
        keep   = KW'((32'd1 << nbytes) - 32'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_q      <= '0;
            acc_q       <= '0;
            m_data_q    <= '0;
            m_keep_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            len_err_q   <= 1'b0;
            elem_cnt_q  <= '0;
            frame_len_q <= '0;
        end else begin
            if (m_valid_q && m_TREADY) begin
                m_valid_q <= 1'b0;
            end
            if (accept) begin
                if (first) begin
                    frame_len_q <= frame_len;
                end
                elem_cnt_q <= frame_end ? '0 : elem_cnt_q + 1'b1;
                if (err_hit) begin
                    len_err_q <= 1'b1;
                end
                if (word_done) begin
                    m_data_q  <= word;
                    m_keep_q  <= keep;
                    m_last_q  <= frame_end;
                    m_valid_q <= 1'b1;
                    acc_q     <= '0;
                    lane_q    <= '0;
                end else begin
                    acc_q  <= word;
                    lane_q <= lane_q + LW'(1);
                end
            end
        end
    end

    assign m_TDATA    = m_data_q;
    assign m_TKEEP    = m_keep_q;
    assign m_TVALID   = m_valid_q;
    assign m_TLAST    = m_last_q;
    assign frame_done = m_valid_q & m_TREADY & m_last_q;
    assign len_err    = len_err_q;

endmodule

// File: doc/gelu_out_pack_axis.md
Name: gelu_out_pack_axis

Overview:
- Output packer placed directly downstream of the GELU matmul stage.
- Consumes the stage's D_W-bit signed result stream, one element per beat.
- Packs 32/D_W consecutive elements, little-endian, into 32-bit AXI-Stream words for the S2MM DMA.
- Closes each frame (one M1×M3 result matrix) with TLAST and a byte-keep mask, and flags length mismatches between upstream TLAST and the programmed frame length.

Parameters:
- D_W, 8, element width in bits; must divide 32; LANES = 32/D_W (4 at default).
- MATRIXSIZE_W, 16, width of the frame-length and element counters.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- frame_len  in  MATRIXSIZE_W  elements per frame; 0 disables the length check.
- s_TDATA  in  D_W  signed element from the GELU stage.
- s_TVALID  in  1  element valid.
- s_TREADY  out  1  element accepted.
- s_TLAST  in  1  last element of the frame, as asserted upstream.
- m_TDATA  out  32  packed word.
- m_TKEEP  out  32/D_W*D_W/8  byte enables (4 bits at default).
- m_TVALID  out  1  word valid.
- m_TREADY  in  1  downstream ready.
- m_TLAST  out  1  word carries the final element of the frame.
- frame_done  out  1  one-cycle pulse on the handshake of the TLAST word.
- len_err  out  1  sticky length-mismatch flag.

Behaviour:
- Reset (async, rst_n=0): all of the following clear immediately.
  - m_TVALID=0, m_TDATA=0, m_TKEEP=0, m_TLAST=0.
  - frame_done=0, len_err=0.
  - lane index=0, element counter=0, accumulator=0.
  - Any partial word is discarded.
- Release of reset is synchronous to clk.
- Ready rule: s_TREADY = ~m_TVALID | m_TREADY. It is purely a function of output occupancy and never depends on s_TVALID.
- Accept condition: an element is accepted when s_TVALID & s_TREADY.
  - It is written into lane index lane at bits [lane*D_W +: D_W], raw two's complement with no sign extension.
  - lane then increments.
- Frame length capture: frame_len is sampled into frame_len_q on acceptance of the first element of a frame (elem_cnt==0). Changes to frame_len mid-frame are ignored.
- End-of-frame condition: end = s_TLAST | (frame_len_q!=0 & elem_cnt==frame_len_q-1).
- Word completion: a word completes when an accepted element has lane==LANES-1 or end=1. On the next clk edge:
  - m_TDATA = packed word, with unused upper lanes zero.
  - m_TKEEP = byte mask of the filled lanes (1 lane→0x1, 2→0x3, 3→0x7, 4→0xF at D_W=8).
  - m_TLAST = end; m_TVALID = 1.
  - Accumulator and lane are cleared.
- Latency: 1 cycle from acceptance of a word's last element to m_TVALID.
- Throughput: 1 element/cycle while m_TREADY is held high.
- Output hold: m_TDATA, m_TKEEP and m_TLAST stay stable while m_TVALID=1 & m_TREADY=0.
- Output clear: m_TVALID drops after handshake unless a new word completes in the same cycle (back-to-back is allowed, because s_TREADY=1 when m_TREADY=1).
- elem_cnt behaviour:
  - Increments per accepted element.
  - Resets to 0 on end.
  - Wraps modulo 2^MATRIXSIZE_W when frame_len=0.
- len_err is set (sticky until reset) when either:
  - s_TLAST arrives with frame_len_q!=0 and elem_cnt!=frame_len_q-1, or
  - elem_cnt reaches frame_len_q-1 without s_TLAST.
- In both error cases the frame still closes at that element.
- frame_done asserts for one cycle when m_TVALID & m_TREADY & m_TLAST.
- Lane state machine: LANE0..LANE(LANES-1).
  - An advance happens only on an accept.
  - Any state returns to LANE0 on word completion.
  - end in LANE0 produces a single-lane word.
- Reset mid-frame: no output is produced for the discarded partial frame. The next frame starts at lane 0 with a new frame_len sample.

Test Plan:
- frame_len=8, elements 1..8, m_TREADY=1 → words 0x04030201 then 0x08070605, both KEEP=0xF, TLAST only on the second word, frame_done pulses once, len_err=0.
- frame_len=6, elements 5,6,7,8,9,10 with s_TLAST on element 10 → 0x08070605 KEEP=0xF, then 0x00000A09 KEEP=0x3 TLAST=1.
- Elements -1,-2 with frame_len=2 → m_TDATA=0x0000FEFF, KEEP=0x3, TLAST=1.
- frame_len=8, s_TLAST on element 3 → word 0x00030201, KEEP=0x7, TLAST=1, len_err=1 and it stays 1 through the next correct frame.
- frame_len=16, s_TVALID continuous, m_TREADY low for 10 cycles after the first word → s_TREADY=0 the whole stall, m_TDATA stable, no element lost or duplicated; 4 words total in order.
- rst_n pulsed low mid-cycle after 3 elements → outputs clear immediately without waiting for clk; a subsequent 4-element frame yields exactly one word 0x04030201.
